// File: rtl/gmii_pkg.sv
// Shared GMII MAC definitions: transmit FSM state encoding, framing bytes and
// CRC-32 constants used by both the transmit and receive sides.
package gmii_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRE     = 3'd1,
        ST_DATA    = 3'd2,
        ST_PAD     = 3'd3,
        ST_FCS     = 3'd4,
        ST_DISCARD = 3'd5,
        ST_IFG     = 3'd6
    } state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_DEFAULT   = 8'hD5;
    localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;

endpackage

// File: rtl/crc32_d8.sv
// Combinational CRC-32 (reflected, LSB-first) advance by one data byte.
module crc32_d8
    import gmii_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  d,
    output logic [31:0] crc_out
);

    // Shift the eight data bits through the reflected polynomial, bit 0 first.
    always_comb begin
        logic [31:0] c;
        c = crc_in;
        for (int unsigned i = 0; i < 8; i++) begin
            if (c[0] ^ d[i]) c = (c >> 1) ^ CRC_POLY;
            else             c = c >> 1;
        end
        crc_out = c;
    end

endmodule

// File: rtl/gmii_mac_tx.sv
// GMII transmit MAC: preamble, SFD, payload, zero pad to minimum size,
// optional FCS and inter-frame gap on registered txd/txen/txer.
// Define GMII_MAC_TX_FCS_EN to generate and append the CRC-32 FCS.
module gmii_mac_tx
    import gmii_pkg::*;
#(
    parameter logic [7:0]  SFD          = SFD_DEFAULT,
    parameter int unsigned PREAMBLE_LEN = 7,
    parameter int unsigned MIN_PAYLOAD  = 60,
    parameter int unsigned IFG_BYTES    = 12
) (
    input  logic       tx_clk,
    input  logic       reset,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [7:0] txd,
    output logic       txen,
    output logic       txer,
    output logic       busy
);

`ifdef GMII_MAC_TX_FCS_EN
    localparam state_t BODY_DONE = ST_FCS;
`else
    localparam state_t BODY_DONE = ST_IFG;
`endif

    state_t      state, state_nxt;
    logic [7:0]  txd_nxt;
    logic        txen_nxt, txer_nxt;
    logic [7:0]  pre_cnt, pre_cnt_nxt;
    logic [7:0]  ifg_cnt, ifg_cnt_nxt;
    logic [15:0] byte_cnt, byte_cnt_nxt;
    logic [15:0] cnt_sat;
    logic [16:0] cnt_inc;

    assign cnt_inc = {1'b0, byte_cnt} + 17'd1;
    assign cnt_sat = (byte_cnt == 16'hFFFF) ? byte_cnt : cnt_inc[15:0];

`ifdef GMII_MAC_TX_FCS_EN
    logic [31:0] crc, crc_nxt, crc_upd, fcs_word;
    logic [7:0]  crc_data;
    logic [1:0]  fcs_cnt, fcs_cnt_nxt;

    // Pad bytes are zeros; only real payload feeds s_data into the CRC.
    assign crc_data = (state == ST_DATA) ? s_data : 8'h00;
    assign fcs_word = ~crc;

    crc32_d8 u_crc (
        .crc_in  (crc),
        .d       (crc_data),
        .crc_out (crc_upd)
    );
`endif

    // Combinational status decode; forced low while reset is held.
    assign s_ready = !reset && (state == ST_DATA || state == ST_DISCARD);
    assign busy    = !reset && (state != ST_IDLE);

    // Next-state and next-output decode; the state names what txd gets next.
    always_comb begin
        state_nxt    = state;
        txd_nxt      = 8'h00;
        txen_nxt     = 1'b0;
        txer_nxt     = 1'b0;
        pre_cnt_nxt  = pre_cnt;
        byte_cnt_nxt = byte_cnt;
        ifg_cnt_nxt  = '0;
`ifdef GMII_MAC_TX_FCS_EN
        crc_nxt      = crc;
        fcs_cnt_nxt  = fcs_cnt;
`endif
        case (state)
            ST_IDLE: begin
                if (s_valid) begin
                    txd_nxt     = PREAMBLE_BYTE;
                    txen_nxt    = 1'b1;
                    pre_cnt_nxt = 8'd1;
                    state_nxt   = ST_PRE;
                end
            end
            ST_PRE: begin
                txen_nxt = 1'b1;
                if (pre_cnt < 8'(PREAMBLE_LEN)) begin
                    txd_nxt     = PREAMBLE_BYTE;
                    pre_cnt_nxt = pre_cnt + 8'd1;
                end else begin
                    txd_nxt      = SFD;
                    byte_cnt_nxt = '0;
`ifdef GMII_MAC_TX_FCS_EN
                    crc_nxt      = CRC_INIT;
                    fcs_cnt_nxt  = '0;
`endif
                    state_nxt    = ST_DATA;
                end
            end
            ST_DATA: begin
                txen_nxt = 1'b1;
                if (s_valid) begin
                    txd_nxt      = s_data;
                    byte_cnt_nxt = cnt_sat;
`ifdef GMII_MAC_TX_FCS_EN
                    crc_nxt      = crc_upd;
`endif
                    if (s_last) begin
                        if (cnt_inc < 17'(MIN_PAYLOAD)) state_nxt = ST_PAD;
                        else                            state_nxt = BODY_DONE;
                    end
                end else begin
                    // Underrun: flag one errored byte, then drop the rest.
                    txer_nxt  = 1'b1;
                    state_nxt = ST_DISCARD;
                end
            end
            ST_PAD: begin
                txen_nxt     = 1'b1;
                byte_cnt_nxt = cnt_sat;
`ifdef GMII_MAC_TX_FCS_EN
                crc_nxt      = crc_upd;
`endif
                if (cnt_inc >= 17'(MIN_PAYLOAD)) state_nxt = BODY_DONE;
            end
`ifdef GMII_MAC_TX_FCS_EN
            ST_FCS: begin
                txen_nxt    = 1'b1;
                txd_nxt     = fcs_word[{fcs_cnt, 3'b000} +: 8];
                fcs_cnt_nxt = fcs_cnt + 2'd1;
                if (fcs_cnt == 2'd3) state_nxt = ST_IFG;
            end
`endif
            ST_DISCARD: begin
                if (s_valid && s_last) state_nxt = ST_IFG;
            end
            ST_IFG: begin
                ifg_cnt_nxt = ifg_cnt + 8'd1;
                if (ifg_cnt == 8'(IFG_BYTES - 1)) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, counters and registered GMII outputs.
    always_ff @(posedge tx_clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            txd      <= '0;
            txen     <= 1'b0;
            txer     <= 1'b0;
            pre_cnt  <= '0;
            ifg_cnt  <= '0;
            byte_cnt <= '0;
`ifdef GMII_MAC_TX_FCS_EN
            crc      <= CRC_INIT;
            fcs_cnt  <= '0;
`endif
        end else begin
            state    <= state_nxt;
            txd      <= txd_nxt;
            txen     <= txen_nxt;
            txer     <= txer_nxt;
            pre_cnt  <= pre_cnt_nxt;
            ifg_cnt  <= ifg_cnt_nxt;
            byte_cnt <= byte_cnt_nxt;
`ifdef GMII_MAC_TX_FCS_EN
            crc      <= crc_nxt;
            fcs_cnt  <= fcs_cnt_nxt;
`endif
        end
    end

endmodule
